// File: rtl/cond_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cond_pkg
// Description : Shared constants for the conditional-execution stage.
//               Condition encodings, NZCV flag bit positions and FlagW bits.
// Revision    : 1.0 - initial release
// ============================================================================
package cond_pkg;

    // Condition field encodings (Instr[31:28])
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // Bit positions inside the {N,Z,C,V} flag vector
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Bit positions inside FlagW
    localparam int FLAGW_NZ = 1;
    localparam int FLAGW_CV = 0;

endpackage : cond_pkg
`default_nettype wire

// File: rtl/cond_check.sv
`default_nettype none
// ============================================================================
// Module      : cond_check
// Description : Purely combinational condition evaluator. Decodes the 4-bit
//               condition field against the architectural NZCV flags.
// Revision    : 1.0 - initial release
// ============================================================================
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] Cond,
    input  logic [3:0] Flags,
    output logic       CondEx
);

    logic w_n;
    logic w_z;
    logic w_c;
    logic w_v;
    logic w_ge;

    assign w_n  = Flags[FLAG_N];
    assign w_z  = Flags[FLAG_Z];
    assign w_c  = Flags[FLAG_C];
    assign w_v  = Flags[FLAG_V];
    assign w_ge = (w_n == w_v);

    // Decode the condition field into a pass/fail result
    always_comb begin
        CondEx = 1'b0;
        case (Cond)
            COND_EQ: CondEx = w_z;
            COND_NE: CondEx = ~w_z;
            COND_CS: CondEx = w_c;
            COND_CC: CondEx = ~w_c;
            COND_MI: CondEx = w_n;
            COND_PL: CondEx = ~w_n;
            COND_VS: CondEx = w_v;
            COND_VC: CondEx = ~w_v;
            COND_HI: CondEx = w_c & ~w_z;
            COND_LS: CondEx = ~w_c | w_z;
            COND_GE: CondEx = w_ge;
            COND_LT: CondEx = ~w_ge;
            COND_GT: CondEx = ~w_z & w_ge;
            COND_LE: CondEx = w_z | ~w_ge;
            COND_AL: CondEx = 1'b1;
            COND_NV: CondEx = 1'b0;
            default: CondEx = 1'b0;
        endcase
    end

endmodule : cond_check
`default_nettype wire

// File: rtl/cond_logic.sv
`default_nettype none
// ============================================================================
// Module      : cond_logic
// Description : Conditional-execution stage. Owns the NZCV flag register,
//               gates PC/register/memory writes with the condition result and
//               optionally counts executed and squashed instructions.
//               Optional feature macro: COND_PERF_CNT_EN (enables counters;
//               when undefined ExecCnt/SquashCnt are tied to zero).
// Revision    : 1.0 - initial release
// ============================================================================
module cond_logic
    import cond_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Enable,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic             PCS,
    input  logic             RegW,
    input  logic             MemW,
    input  logic             NoWrite,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             CondEx,
    output logic [3:0]       Flags,
    output logic [CNT_W-1:0] ExecCnt,
    output logic [CNT_W-1:0] SquashCnt
);

    logic [3:0] r_flags;
    logic       w_cond_ex;
    logic       w_exec;
    logic       w_squash;

    // Condition is always judged against the registered flags, never ALUFlags
    cond_check u_cond_check (
        .Cond   (Cond),
        .Flags  (r_flags),
        .CondEx (w_cond_ex)
    );

    assign w_exec   = Enable & w_cond_ex;
    assign w_squash = Enable & ~w_cond_ex;

    assign CondEx   = w_cond_ex;
    assign Flags    = r_flags;
    assign PCSrc    = PCS  & w_exec;
    assign RegWrite = RegW & w_exec & ~NoWrite;
    assign MemWrite = MemW & w_exec;

    // NZCV register: the two halves update independently, only for executed ops
    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags <= 4'b0000;
        end else if (w_exec) begin
            if (FlagW[FLAGW_NZ]) begin
                r_flags[FLAG_N] <= ALUFlags[FLAG_N];
                r_flags[FLAG_Z] <= ALUFlags[FLAG_Z];
            end
            if (FlagW[FLAGW_CV]) begin
                r_flags[FLAG_C] <= ALUFlags[FLAG_C];
                r_flags[FLAG_V] <= ALUFlags[FLAG_V];
            end
        end
    end

`ifdef COND_PERF_CNT_EN
    logic [CNT_W-1:0] r_exec_cnt;
    logic [CNT_W-1:0] r_squash_cnt;

    // Execute/squash counters; exactly one advances per enabled cycle, wrapping
    always_ff @(posedge clk) begin
        if (reset) begin
            r_exec_cnt   <= '0;
            r_squash_cnt <= '0;
        end else begin
            if (w_exec) begin
                r_exec_cnt <= r_exec_cnt + 1'b1;
            end
            if (w_squash) begin
                r_squash_cnt <= r_squash_cnt + 1'b1;
            end
        end
    end

    assign ExecCnt   = r_exec_cnt;
    assign SquashCnt = r_squash_cnt;
`else
    logic w_unused_squash;
    assign w_unused_squash = w_squash;
    assign ExecCnt         = '0;
    assign SquashCnt       = '0;
`endif

endmodule : cond_logic
`default_nettype wire

// File: tb/tb_cond_logic.sv
`default_nettype none
// ============================================================================
// Module      : tb_cond_logic
// Description : Self-checking bench for cond_logic: behavioural model with a
//               per-cycle compare process plus directed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cond_logic;

    localparam int CNT_W = 4;
`ifdef COND_PERF_CNT_EN
    localparam bit HAS_CNT = 1'b1;
`else
    localparam bit HAS_CNT = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             Enable = 1'b0;
    logic [3:0]       Cond = 4'd0;
    logic [3:0]       ALUFlags = 4'd0;
    logic [1:0]       FlagW = 2'd0;
    logic             PCS = 1'b0;
    logic             RegW = 1'b0;
    logic             MemW = 1'b0;
    logic             NoWrite = 1'b0;
    logic             PCSrc;
    logic             RegWrite;
    logic             MemWrite;
    logic             CondEx;
    logic [3:0]       Flags;
    logic [CNT_W-1:0] ExecCnt;
    logic [CNT_W-1:0] SquashCnt;

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;

    cond_logic #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .Enable    (Enable),
        .Cond      (Cond),
        .ALUFlags  (ALUFlags),
        .FlagW     (FlagW),
        .PCS       (PCS),
        .RegW      (RegW),
        .MemW      (MemW),
        .NoWrite   (NoWrite),
        .PCSrc     (PCSrc),
        .RegWrite  (RegWrite),
        .MemWrite  (MemWrite),
        .CondEx    (CondEx),
        .Flags     (Flags),
        .ExecCnt   (ExecCnt),
        .SquashCnt (SquashCnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [3:0]       m_flags = 4'd0;
    int               m_exec = 0;
    int               m_squash = 0;

    // Truth of each condition, built as a 16-entry table from named flags
    function automatic bit passes(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v;
        bit [15:0] tbl;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        tbl[0]  = z;           tbl[1]  = !z;
        tbl[2]  = cy;          tbl[3]  = !cy;
        tbl[4]  = n;           tbl[5]  = !n;
        tbl[6]  = v;           tbl[7]  = !v;
        tbl[8]  = cy && !z;    tbl[9]  = !cy || z;
        tbl[10] = (n == v);    tbl[11] = (n != v);
        tbl[12] = !z && (n == v);
        tbl[13] = z || (n != v);
        tbl[14] = 1'b1;        tbl[15] = 1'b0;
        return tbl[c];
    endfunction

    function automatic logic [31:0] cnt_exp(input int v);
        return HAS_CNT ? (v % (1 << CNT_W)) : 0;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_flags  <= 4'd0;
            m_exec   <= 0;
            m_squash <= 0;
        end else if (Enable) begin
            if (passes(Cond, m_flags)) begin
                m_exec <= m_exec + 1;
                m_flags <= { FlagW[1] ? ALUFlags[3:2] : m_flags[3:2],
                             FlagW[0] ? ALUFlags[1:0] : m_flags[1:0] };
            end else begin
                m_squash <= m_squash + 1;
            end
        end
    end

    // Compare every cycle, away from the active edge
    always @(negedge clk) begin
        if (chk_on) begin
            bit p;
            p = passes(Cond, m_flags);
            chk("CondEx",    {31'd0, CondEx},   {31'd0, p});
            chk("PCSrc",     {31'd0, PCSrc},    {31'd0, PCS  && p && Enable});
            chk("RegWrite",  {31'd0, RegWrite}, {31'd0, RegW && p && !NoWrite && Enable});
            chk("MemWrite",  {31'd0, MemWrite}, {31'd0, MemW && p && Enable});
            chk("Flags",     {28'd0, Flags},    {28'd0, m_flags});
            chk("ExecCnt",   {28'd0, ExecCnt},  cnt_exp(m_exec));
            chk("SquashCnt", {28'd0, SquashCnt}, cnt_exp(m_squash));
        end
    end

    // Apply one cycle of stimulus just after the rising edge
    task automatic step(input logic rst, input logic en, input logic [3:0] c,
                        input logic [3:0] af, input logic [1:0] fw,
                        input logic pcs, input logic rw, input logic mw,
                        input logic nw);
        @(posedge clk);
        #1;
        reset = rst; Enable = en; Cond = c; ALUFlags = af; FlagW = fw;
        PCS = pcs; RegW = rw; MemW = mw; NoWrite = nw;
        #2;
    endtask

    localparam logic [3:0] AL = 4'b1110;
    localparam logic [3:0] EQ = 4'b0000;

    initial begin
        logic [3:0] pats [10];
        pats = '{4'h0, 4'h4, 4'h8, 4'h2, 4'h1, 4'h9, 4'h6, 4'hF, 4'hA, 4'h5};

        @(posedge clk);
        #1 chk_on = 1'b1;
        @(posedge clk);

        // AL register write straight out of reset
        step(0, 1, AL, 4'h0, 2'b00, 0, 1, 0, 0);
        chk("t1_RegWrite", {31'd0, RegWrite}, 32'd1);
        chk("t1_CondEx",   {31'd0, CondEx},   32'd1);
        chk("t1_Flags",    {28'd0, Flags},    32'd0);
        // EQ with Z clear: squashed, flags must not change
        step(0, 1, EQ, 4'b0100, 2'b11, 0, 0, 1, 0);
        chk("t1_ExecCnt",  {28'd0, ExecCnt},  cnt_exp(1));
        chk("t2_MemWrite", {31'd0, MemWrite}, 32'd0);
        chk("t2_CondEx",   {31'd0, CondEx},   32'd0);
        // AL compare
        step(0, 1, AL, 4'b0110, 2'b11, 0, 1, 0, 1);
        chk("t2_Flags",    {28'd0, Flags},    32'd0);
        chk("t2_Squash",   {28'd0, SquashCnt}, cnt_exp(1));
        chk("t3_RegWrite", {31'd0, RegWrite}, 32'd0);
        // EQ branch now taken on Z from the compare
        step(0, 1, EQ, 4'h0, 2'b00, 1, 0, 0, 0);
        chk("t3_Flags",    {28'd0, Flags},    32'h6);
        chk("t3_PCSrc",    {31'd0, PCSrc},    32'd1);
        // Independent half updates
        step(0, 1, AL, 4'h0, 2'b11, 0, 0, 0, 0);
        step(0, 1, AL, 4'b1011, 2'b10, 0, 0, 0, 0);
        chk("t4_Flags0",   {28'd0, Flags},    32'h0);
        step(0, 1, AL, 4'b0011, 2'b01, 0, 0, 0, 0);
        chk("t4_FlagsNZ",  {28'd0, Flags},    32'h8);
        // Stall cycle
        step(0, 0, AL, 4'hF, 2'b11, 0, 1, 0, 0);
        chk("t4_FlagsCV",  {28'd0, Flags},    32'hB);
        chk("t5_RegWrite", {31'd0, RegWrite}, 32'd0);
        chk("t5_ExecCnt",  {28'd0, ExecCnt},  cnt_exp(6));
        step(0, 0, AL, 4'h0, 2'b00, 0, 0, 0, 0);
        chk("t5_Flags",    {28'd0, Flags},    32'hB);
        chk("t5_ExecHold", {28'd0, ExecCnt},  cnt_exp(6));
        chk("t5_SqHold",   {28'd0, SquashCnt}, cnt_exp(1));

        // Every condition against a spread of flag patterns
        foreach (pats[i]) begin
            step(0, 1, AL, pats[i], 2'b11, 0, 0, 0, 0);
            for (int c = 0; c < 16; c++) begin
                logic [3:0] cc;
                cc = c[3:0];
                step(0, 1, cc, 4'h0, 2'b00, 1, 1, 1, cc[0]);
            end
        end

        // Random traffic
        for (int k = 0; k < 80; k++) begin
            step(0, ($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom),
                 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom));
        end

        // Reset wins over an enabled flag-writing instruction
        step(1, 1, AL, 4'hF, 2'b11, 1, 1, 1, 0);
        step(0, 0, AL, 4'h0, 2'b00, 0, 0, 0, 0);
        chk("t6_Flags",    {28'd0, Flags},    32'h0);
        chk("t6_ExecCnt",  {28'd0, ExecCnt},  32'd0);
        chk("t6_SqCnt",    {28'd0, SquashCnt}, 32'd0);

        // Counter wrap at all-ones
        for (int k = 0; k < 15; k++) step(0, 1, AL, 4'h0, 2'b00, 0, 0, 0, 0);
        step(0, 0, AL, 4'h0, 2'b00, 0, 0, 0, 0);
        chk("t7_ExecOnes", {28'd0, ExecCnt},  cnt_exp(15));
        step(0, 1, AL, 4'h0, 2'b00, 0, 0, 0, 0);
        step(0, 0, AL, 4'h0, 2'b00, 0, 0, 0, 0);
        chk("t7_ExecWrap", {28'd0, ExecCnt},  32'd0);

        @(posedge clk);
        #1 chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_cond_logic
`default_nettype wire

// File: doc/cond_logic.md
# cond_logic

Conditional-execution stage directly downstream of the instruction decoder. Consumes the decoder's raw control intents (PCS, RegW, MemW, NoWrite, FlagW) plus the instruction condition field and the ALU flags. Evaluates the condition against the architectural NZCV flag register and gates the writes that reach the register file, data memory and PC mux. Owns the NZCV register itself and updates it under FlagW control.

## Interface
Parameters:
- CNT_W, 32, width of the optional execute/squash counters

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- Enable  in  1  instruction valid this cycle; 0 = stall/bubble, no state change
- Cond  in  4  instruction condition field, Instr[31:28]
- ALUFlags  in  4  {N,Z,C,V} from the ALU for the current instruction
- FlagW  in  2  decoder flag-write request: [1] = N,Z; [0] = C,V
- PCS  in  1  decoder PC-write intent
- RegW  in  1  decoder register-write intent
- MemW  in  1  decoder memory-write intent
- NoWrite  in  1  compare-class instruction; suppress register write
- PCSrc  out  1  gated PC-write select
- RegWrite  out  1  gated register-file write enable
- MemWrite  out  1  gated data-memory write enable
- CondEx  out  1  condition passed for the current instruction
- Flags  out  4  current architectural {N,Z,C,V}; C feeds ALU carry-in
- ExecCnt  out  CNT_W  count of executed instructions
- SquashCnt  out  CNT_W  count of squashed instructions

## Operation
- Condition evaluated combinationally against the registered Flags, never against ALUFlags.
- Cond decode, with N,Z,C,V taken from Flags:
  - 0000 EQ: Z
  - 0001 NE: !Z
  - 0010 CS: C
  - 0011 CC: !C
  - 0100 MI: N
  - 0101 PL: !N
  - 0110 VS: V
  - 0111 VC: !V
  - 1000 HI: C&!Z
  - 1001 LS: !C|Z
  - 1010 GE: N==V
  - 1011 LT: N!=V
  - 1100 GT: !Z&(N==V)
  - 1101 LE: Z|(N!=V)
  - 1110 AL: 1
  - 1111: 0 (never)
- Gated outputs:
  - PCSrc = PCS & CondEx & Enable
  - RegWrite = RegW & CondEx & !NoWrite & Enable
  - MemWrite = MemW & CondEx & Enable
- CondEx is the raw condition result and is not gated by Enable.
- Flag update at the rising edge when Enable & CondEx:
  - FlagW[1]=1 loads Flags[3:2] from ALUFlags[3:2].
  - FlagW[0]=1 loads Flags[1:0] from ALUFlags[1:0].
  - Each half updates independently.
- A squashed instruction (CondEx=0) never updates flags, even with FlagW set.
- Counters (CNT_W wide, wrap modulo 2^CNT_W):
  - ExecCnt increments when Enable & CondEx.
  - SquashCnt increments when Enable & !CondEx.
  - Exactly one counter increments per enabled cycle.

## Timing
- Gated outputs are combinational from the inputs and the Flags register, with zero latency.
- A flag written by instruction k is visible to the condition of instruction k+1, on the next enabled cycle.
- Reset, synchronous, wins over Enable:
  - Flags=0000, ExecCnt=0, SquashCnt=0.
  - In the reset cycle, combinational outputs still follow inputs against Flags=0000; they are not forced to 0.
- Enable=0: Flags and counters hold; PCSrc, RegWrite and MemWrite are 0.
- Counter wrap: all-ones + 1 -> 0, with no saturation or flag.

## Configuration
- COND_PERF_CNT_EN defined: ExecCnt/SquashCnt registers are implemented as specified.
- COND_PERF_CNT_EN undefined:
  - No counter registers.
  - ExecCnt and SquashCnt ports remain and are tied to 0.
  - All other behaviour is identical.

## Structure
- Shared package cond_pkg holds:
  - localparams for the 16 condition encodings (COND_EQ … COND_NV)
  - flag bit indices (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0)
  - FlagW bit indices
- Sub-module cond_check: purely combinational, Cond + Flags -> CondEx.
- cond_logic holds the flag register, output gating and the optional counters.

## Test plan
- Reset, then Cond=1110 (AL), RegW=1, NoWrite=0, Enable=1 -> RegWrite=1, CondEx=1, Flags=0000, ExecCnt=1 after the edge.
- Flags=0000, Cond=0000 (EQ), MemW=1, FlagW=11, ALUFlags=0100 -> MemWrite=0, CondEx=0; Flags stay 0000; SquashCnt increments.
- AL CMP with FlagW=11, NoWrite=1, RegW=1, ALUFlags=0110 -> RegWrite=0; next cycle Flags=0110; then Cond=0000 with PCS=1 -> PCSrc=1.
- Flags=0000, AL instruction with FlagW=10, ALUFlags=1011 -> Flags=1000 (C,V untouched). Then FlagW=01, ALUFlags=0011 -> Flags=1011.
- Enable=0 with Cond=AL, RegW=1, FlagW=11, ALUFlags=1111 -> RegWrite=0; Flags and both counters unchanged.
- Counters:
  - Preload ExecCnt to all-ones (force) and run an AL instruction -> ExecCnt=0.
  - Assert reset with Enable=1, FlagW=11 -> Flags=0000 and counters 0.
  - Rebuild without COND_PERF_CNT_EN -> counters read 0 throughout.
